dm_ext_master: RTL and testbench

DM_EXT_MASTER -- requirements
Module: dm_ext_master

---
 rtl/dm_ext_master.sv | 186 ++++++++++++++++++
 tb/tb_dm_ext_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ext_master.sv
// -----------------------------------------------------------------------------
// dm_ext_master
// Command-driven master for an external synchronous data memory with a fixed
// read latency. Accepts single-word writes and wrapping burst reads, drives
// registered memory-side control/address/data, and returns read words as
// one-cycle response pulses in issue order.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//   cmd_wr                   1 = single write, 0 = burst read
//   cmd_addr                 write address / burst start address
//   cmd_len                  burst length (0 -> 1, clamped to 2^DMA_SIZE)
//   cmd_wdata                write data
//   rsp_valid/data/last      read response stream, no backpressure
//   busy                     high whenever not IDLE
//   ps_dm_cslt, ps_dm_wrb    memory chip select / write strobe
//   dg_dm_add, bc_dt         memory address / write data
//   dm_bc_dt                 memory read data (valid READ_LAT cycles after issue)
// -----------------------------------------------------------------------------
module dm_ext_master #(
    parameter int DMA_SIZE = 3,
    parameter int DMD_SIZE = 4,
    parameter int READ_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [DMA_SIZE-1:0] cmd_addr,
    input  logic [DMA_SIZE:0]   cmd_len,
    input  logic [DMD_SIZE-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [DMD_SIZE-1:0] rsp_data,
    output logic                rsp_last,
    output logic                busy,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [DMA_SIZE:0]   LEN_ONE  = (DMA_SIZE+1)'(1);
    localparam logic [DMA_SIZE:0]   LEN_MAX  = LEN_ONE << DMA_SIZE;
    localparam logic [DMA_SIZE-1:0] ADDR_ONE = DMA_SIZE'(1);

    state_t              state_q;
    logic [DMA_SIZE-1:0] addr_cnt_q;    // address of the next read to issue
    logic [DMA_SIZE:0]   rem_q;         // reads still to issue after the current one
    logic [READ_LAT:0]   pipe_vld_q;    // in-flight read tracker, stage i = i cycles after issue
    logic [READ_LAT:0]   pipe_last_q;
    logic                cslt_q;
    logic                wrb_q;
    logic [DMA_SIZE-1:0] add_q;
    logic [DMD_SIZE-1:0] bc_dt_q;
    logic                rsp_valid_q;
    logic                rsp_last_q;
    logic [DMD_SIZE-1:0] rsp_data_q;

    logic [DMA_SIZE:0]   eff_len_s;
    logic                accept_s;

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign accept_s   = cmd_valid && cmd_ready;

    assign ps_dm_cslt = cslt_q;
    assign ps_dm_wrb  = wrb_q;
    assign dg_dm_add  = add_q;
    assign bc_dt      = bc_dt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_data   = rsp_data_q;

    // Effective burst length: zero means one word, anything beyond the
    // address space is clamped so a burst never revisits an address.
    always_comb begin
        eff_len_s = cmd_len;
        if (cmd_len == {(DMA_SIZE+1){1'b0}}) begin
            eff_len_s = LEN_ONE;
        end else if (cmd_len > LEN_MAX) begin
            eff_len_s = LEN_MAX;
        end else begin
            eff_len_s = cmd_len;
        end
    end

    // Controller FSM with registered memory-side and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_cnt_q  <= {DMA_SIZE{1'b0}};
            rem_q       <= {(DMA_SIZE+1){1'b0}};
            pipe_vld_q  <= {(READ_LAT+1){1'b0}};
            pipe_last_q <= {(READ_LAT+1){1'b0}};
            cslt_q      <= 1'b0;
            wrb_q       <= 1'b0;
            add_q       <= {DMA_SIZE{1'b0}};
            bc_dt_q     <= {DMD_SIZE{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= {DMD_SIZE{1'b0}};
        end else begin
            // Age every in-flight read by one cycle; stage 0 is refilled
            // below only when a read is issued in the coming cycle.
            for (int i = READ_LAT; i > 0; i--) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
            pipe_vld_q[0]  <= 1'b0;
            pipe_last_q[0] <= 1'b0;

            // The oldest stage holds a read whose data is on dm_bc_dt now.
            rsp_valid_q <= pipe_vld_q[READ_LAT];
            rsp_last_q  <= pipe_vld_q[READ_LAT] & pipe_last_q[READ_LAT];
            if (pipe_vld_q[READ_LAT]) begin
                rsp_data_q <= dm_bc_dt;
            end

            case (state_q)
                IDLE: begin
                    cslt_q <= 1'b0;
                    wrb_q  <= 1'b0;
                    if (accept_s) begin
                        cslt_q <= 1'b1;
                        add_q  <= cmd_addr;
                        if (cmd_wr) begin
                            state_q <= WRITE;
                            wrb_q   <= 1'b1;
                            bc_dt_q <= cmd_wdata;
                        end else begin
                            // First read goes out in the cycle after accept.
                            state_q        <= READ;
                            addr_cnt_q     <= cmd_addr + ADDR_ONE;
                            rem_q          <= eff_len_s - LEN_ONE;
                            pipe_vld_q[0]  <= 1'b1;
                            pipe_last_q[0] <= (eff_len_s == LEN_ONE);
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    cslt_q  <= 1'b0;
                    wrb_q   <= 1'b0;
                end
                READ: begin
                    wrb_q <= 1'b0;
                    if (rem_q == {(DMA_SIZE+1){1'b0}}) begin
                        state_q <= DRAIN;
                        cslt_q  <= 1'b0;
                    end else begin
                        cslt_q         <= 1'b1;
                        add_q          <= addr_cnt_q;
                        addr_cnt_q     <= addr_cnt_q + ADDR_ONE;
                        rem_q          <= rem_q - LEN_ONE;
                        pipe_vld_q[0]  <= 1'b1;
                        pipe_last_q[0] <= (rem_q == LEN_ONE);
                    end
                end
                DRAIN: begin
                    cslt_q <= 1'b0;
                    wrb_q  <= 1'b0;
                    // Hold off new commands until the final word has left.
                    if (rsp_valid_q && rsp_last_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cslt_q  <= 1'b0;
                    wrb_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_ext_master.sv
// -----------------------------------------------------------------------------
// tb_dm_ext_master
// Directed bench for dm_ext_master with default parameters. A small behavioural
// memory (8 x 4 bit, read latency 3) sits on the memory port. Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dm_ext_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [3:0] cmd_wdata;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic       ps_dm_cslt;
    logic       ps_dm_wrb;
    logic [2:0] dg_dm_add;
    logic [3:0] bc_dt;
    logic [3:0] dm_bc_dt;

    logic       mem_init;
    logic [3:0] mem [0:7];
    logic [3:0] dly [0:2];

    int n_total = 0;
    int n_pass  = 0;

    logic [2:0] exp_add [0:7];
    logic [3:0] exp_dat [0:7];

    always #5 clk = ~clk;

    dm_ext_master dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .busy       (busy),
        .ps_dm_cslt (ps_dm_cslt),
        .ps_dm_wrb  (ps_dm_wrb),
        .dg_dm_add  (dg_dm_add),
        .bc_dt      (bc_dt),
        .dm_bc_dt   (dm_bc_dt)
    );

    // Memory model: read issued in cycle t appears on dm_bc_dt in cycle t+3.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 4'(i + 1);
            end
            dly[0] <= 4'h0;
            dly[1] <= 4'h0;
            dly[2] <= 4'h0;
        end else begin
            if (ps_dm_cslt && ps_dm_wrb) begin
                mem[dg_dm_add] <= bc_dt;
            end
            dly[0] <= (ps_dm_cslt && !ps_dm_wrb) ? mem[dg_dm_add] : 4'h0;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
        end
    end
    assign dm_bc_dt = dly[2];

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_exp(input int i, input logic [2:0] a, input logic [3:0] d);
        exp_add[i] = a;
        exp_dat[i] = d;
    endtask

    // Called at a falling edge in IDLE. Accept happens this cycle (cycle 0);
    // issues expected in cycles 1..n, responses in cycles 5..n+4, IDLE at n+5.
    // With hold=1, cmd_valid stays high carrying a write that must be taken
    // exactly in cycle n+5.
    task automatic do_read(input logic [2:0] addr, input logic [3:0] len, input int n,
                           input logic hold, input logic [2:0] waddr, input logic [3:0] wdat);
        check_val("rd_accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int k = 1; k <= n + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    cmd_wr    = 1'b1;
                    cmd_addr  = waddr;
                    cmd_wdata = wdat;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            check_val("rd_cslt", 32'(ps_dm_cslt), 32'(k <= n));
            check_val("rd_wrb", 32'(ps_dm_wrb), 32'd0);
            if (k <= n) begin
                check_val("rd_addr", 32'(dg_dm_add), 32'(exp_add[k-1]));
            end
            check_val("rd_rsp_valid", 32'(rsp_valid), 32'(k >= 5 && k <= n + 4));
            if (k >= 5 && k <= n + 4) begin
                check_val("rd_rsp_data", 32'(rsp_data), 32'(exp_dat[k-5]));
            end
            check_val("rd_rsp_last", 32'(rsp_last), 32'(k == n + 4));
            check_val("rd_cmd_ready", 32'(cmd_ready), 32'(k == n + 5));
            check_val("rd_busy", 32'(busy), 32'(k != n + 5));
        end
        check_val("rd_data_hold", 32'(rsp_data), 32'(exp_dat[n-1]));
    endtask

    // Called at the falling edge of the accept cycle of a write.
    task automatic write_tail(input logic [2:0] addr, input logic [3:0] data);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("wr_cslt", 32'(ps_dm_cslt), 32'd1);
        check_val("wr_wrb", 32'(ps_dm_wrb), 32'd1);
        check_val("wr_addr", 32'(dg_dm_add), 32'(addr));
        check_val("wr_data", 32'(bc_dt), 32'(data));
        check_val("wr_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check_val("wr_end_cslt", 32'(ps_dm_cslt), 32'd0);
        check_val("wr_end_wrb", 32'(ps_dm_wrb), 32'd0);
        check_val("wr_addr_hold", 32'(dg_dm_add), 32'(addr));
        check_val("wr_data_hold", 32'(bc_dt), 32'(data));
        check_val("wr_end_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int rsp_seen;
        rst       = 1'b1;
        cmd_valid = 1'b1;   // must be ignored while in reset
        cmd_wr    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_len   = 4'd0;
        cmd_wdata = 4'h0;
        mem_init  = 1'b1;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        mem_init  = 1'b0;

        // Reset state
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_cslt", 32'(ps_dm_cslt), 32'd0);
        check_val("rst_wrb", 32'(ps_dm_wrb), 32'd0);
        check_val("rst_addr", 32'(dg_dm_add), 32'd0);
        check_val("rst_bc_dt", 32'(bc_dt), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_last", 32'(rsp_last), 32'd0);
        check_val("rst_rsp_data", 32'(rsp_data), 32'd0);

        // Write addr 5 data 0xA, then read it back
        check_val("wr_accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 3'd5;
        cmd_wdata = 4'hA;
        write_tail(3'd5, 4'hA);
        set_exp(0, 3'd5, 4'hA);
        do_read(3'd5, 4'd1, 1, 1'b0, 3'd0, 4'h0);

        // Wrapping burst addr 6 len 4
        set_exp(0, 3'd6, 4'h7);
        set_exp(1, 3'd7, 4'h8);
        set_exp(2, 3'd0, 4'h1);
        set_exp(3, 3'd1, 4'h2);
        do_read(3'd6, 4'd4, 4, 1'b0, 3'd0, 4'h0);

        // len 0 behaves as len 1
        set_exp(0, 3'd2, 4'h3);
        do_read(3'd2, 4'd0, 1, 1'b0, 3'd0, 4'h0);

        // len 8 with cmd_valid held; queued write addr 0 data 0xC taken after drain
        set_exp(0, 3'd4, 4'h5);
        set_exp(1, 3'd5, 4'hA);
        set_exp(2, 3'd6, 4'h7);
        set_exp(3, 3'd7, 4'h8);
        set_exp(4, 3'd0, 4'h1);
        set_exp(5, 3'd1, 4'h2);
        set_exp(6, 3'd2, 4'h3);
        set_exp(7, 3'd3, 4'h4);
        do_read(3'd4, 4'd8, 8, 1'b1, 3'd0, 4'hC);
        write_tail(3'd0, 4'hC);

        // len 15 clamps to 8 words
        set_exp(0, 3'd1, 4'h2);
        set_exp(1, 3'd2, 4'h3);
        set_exp(2, 3'd3, 4'h4);
        set_exp(3, 3'd4, 4'h5);
        set_exp(4, 3'd5, 4'hA);
        set_exp(5, 3'd6, 4'h7);
        set_exp(6, 3'd7, 4'h8);
        set_exp(7, 3'd0, 4'hC);
        do_read(3'd1, 4'd15, 8, 1'b0, 3'd0, 4'h0);

        // Read addr 3 followed at once by write addr 3: read sees old value
        set_exp(0, 3'd3, 4'h4);
        do_read(3'd3, 4'd1, 1, 1'b1, 3'd3, 4'hF);
        write_tail(3'd3, 4'hF);
        set_exp(0, 3'd3, 4'hF);
        do_read(3'd3, 4'd1, 1, 1'b0, 3'd0, 4'h0);

        // Reset two cycles into a len-8 burst
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_len   = 4'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("abort_issue1", 32'(ps_dm_cslt), 32'd1);
        @(negedge clk);
        check_val("abort_issue2_addr", 32'(dg_dm_add), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_cslt", 32'(ps_dm_cslt), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd1);
        check_val("abort_busy", 32'(busy), 32'd0);
        rsp_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid || ps_dm_cslt) begin
                rsp_seen++;
            end
        end
        check_val("abort_no_rsp", 32'(rsp_seen), 32'd0);
        check_val("abort_rsp_data", 32'(rsp_data), 32'd0);
        check_val("abort_ready_end", 32'(cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
